// File: rtl/video_pkg.sv
// rtl/video_pkg.sv - shared state encoding, timing defaults and address helper for video_capture
package video_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_CAPTURE = 2'd2
   } state_t;

   localparam int   DEF_H_START  = 48;
   localparam int   DEF_H_ACTIVE = 256;
   localparam int   DEF_V_START  = 16;
   localparam int   DEF_V_ACTIVE = 240;
   localparam logic DEF_SYNC_POL = 1'b1;

   localparam logic [8:0] CNT_MAX    = 9'd511;
   localparam int         FIFO_DEPTH = 4;

   // Byte address of the pixel pair holding pix_off on line line_off, relative to the active window.
   function automatic logic [14:0] pixel_addr(input logic [8:0] line_off, input logic [8:0] pix_off,
                                              input int half_width);
      return 15'(32'(line_off) * 32'(half_width) + 32'(pix_off >> 1));
   endfunction

endpackage

// File: rtl/capture_fifo.sv
// rtl/capture_fifo.sv - four-entry write queue; a push into a full queue only lands if the head pops that cycle
module capture_fifo
   import video_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             empty,
   output logic             full
);

   localparam int AW = $clog2(FIFO_DEPTH);

   logic [WIDTH-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(FIFO_DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

endmodule

// File: rtl/video_capture.sv
// rtl/video_capture.sv - captures a 4-bit video window into a packed frame buffer through a small write queue
module video_capture
   import video_pkg::*;
#(
   parameter int   H_START  = DEF_H_START,
   parameter int   H_ACTIVE = DEF_H_ACTIVE,
   parameter int   V_START  = DEF_V_START,
   parameter int   V_ACTIVE = DEF_V_ACTIVE,
   parameter logic SYNC_POL = DEF_SYNC_POL
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic        hSync,
   input  logic        vSync,
   input  logic [3:0]  rgb,
   output logic [14:0] memAddr,
   output logic [7:0]  memData,
   output logic        memWrite,
   input  logic        memReady,
   output logic        locked,
   output logic        frameDone,
   output logic        overflow
);

   localparam logic [8:0] H_LO = 9'(H_START);
   localparam logic [8:0] H_HI = 9'(H_START + H_ACTIVE);
   localparam logic [8:0] V_LO = 9'(V_START);
   localparam logic [8:0] V_HI = 9'(V_START + V_ACTIVE);

   state_t      state;
   state_t      state_next;
   logic        hs_q, hs_prev, vs_q, vs_prev;
   logic [3:0]  rgb_q, rgb_d;
   logic        h_fall, v_fall;
   logic [8:0]  h_count, line_count;
   logic [8:0]  h_off, v_off;
   logic        capture;
   logic [3:0]  hi_nibble;
   logic        half_valid;
   logic        push_valid;
   logic [14:0] push_addr;
   logic [7:0]  push_data;
   logic [22:0] fifo_head;
   logic        fifo_empty, fifo_full;
   logic        pop;

   // rgb_d lines up with the counters so hCount 0 is the first deasserted sync sample.
   always_ff @(posedge clk) begin
      if (reset) begin
         hs_q    <= ~SYNC_POL;
         hs_prev <= ~SYNC_POL;
         vs_q    <= ~SYNC_POL;
         vs_prev <= ~SYNC_POL;
         rgb_q   <= '0;
         rgb_d   <= '0;
      end else begin
         hs_q    <= hSync;
         hs_prev <= hs_q;
         vs_q    <= vSync;
         vs_prev <= vs_q;
         rgb_q   <= rgb;
         rgb_d   <= rgb_q;
      end
   end

   assign h_fall = (hs_prev == SYNC_POL) && (hs_q != SYNC_POL);
   assign v_fall = (vs_prev == SYNC_POL) && (vs_q != SYNC_POL);

   always_ff @(posedge clk) begin
      if (reset) begin
         h_count    <= '0;
         line_count <= '0;
      end else begin
         if (h_fall) begin
            h_count <= '0;
         end else if (h_count != CNT_MAX) begin
            h_count <= h_count + 9'd1;
         end
         if (v_fall) begin
            line_count <= '0;
         end else if (h_fall && line_count != CNT_MAX) begin
            line_count <= line_count + 9'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      frameDone  = 1'b0;
      if (!enable) begin
         state_next = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE:    state_next = ST_ARMED;
            ST_ARMED:   if (v_fall) state_next = ST_CAPTURE;
            ST_CAPTURE: begin
               // A new vSync restarts the frame in place rather than completing it.
               if (!v_fall && line_count == V_HI) begin
                  state_next = ST_ARMED;
                  frameDone  = 1'b1;
               end
            end
            default:    state_next = ST_IDLE;
         endcase
      end
   end

   assign locked  = (state == ST_CAPTURE);
   assign h_off   = h_count - H_LO;
   assign v_off   = line_count - V_LO;
   assign capture = locked && enable && (h_count >= H_LO) && (h_count < H_HI)
                    && (line_count >= V_LO) && (line_count < V_HI);

   always_ff @(posedge clk) begin
      if (reset) begin
         hi_nibble  <= '0;
         half_valid <= 1'b0;
         push_valid <= 1'b0;
         push_addr  <= '0;
         push_data  <= '0;
      end else begin
         push_valid <= 1'b0;
         if (!capture) begin
            half_valid <= 1'b0;
         end else if (!h_off[0]) begin
            hi_nibble  <= rgb_d;
            half_valid <= 1'b1;
         end else begin
            half_valid <= 1'b0;
            if (half_valid) begin
               push_valid <= 1'b1;
               push_data  <= {hi_nibble, rgb_d};
               push_addr  <= pixel_addr(v_off, h_off, H_ACTIVE / 2);
            end
         end
      end
   end

   capture_fifo #(
      .WIDTH(23)
   ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (push_valid),
      .push_data({push_addr, push_data}),
      .pop      (pop),
      .head     (fifo_head),
      .empty    (fifo_empty),
      .full     (fifo_full)
   );

   assign memWrite = !fifo_empty;
   assign pop      = memWrite && memReady;
   assign memAddr  = fifo_empty ? 15'd0 : fifo_head[22:8];
   assign memData  = fifo_empty ? 8'd0 : fifo_head[7:0];

   always_ff @(posedge clk) begin
      if (reset) begin
         overflow <= 1'b0;
      end else if (push_valid && fifo_full && !pop) begin
         overflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_video_capture.sv
// tb/tb_video_capture.sv - randomized frame stimulus checked against a pixel-to-byte reference model
module tb_video_capture;

   localparam int HS          = 6;
   localparam int HA          = 16;
   localparam int VS          = 3;
   localparam int VA          = 6;
   localparam int HW          = HA / 2;
   localparam int HE          = HS + HA;
   localparam int VE          = VS + VA;
   localparam int LINE_LO     = HE + 4;
   localparam int FRAME_BYTES = VA * HW;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b0;
   logic        hSync = 1'b0;
   logic        vSync = 1'b0;
   logic [3:0]  rgb = '0;
   logic [14:0] memAddr;
   logic [7:0]  memData;
   logic        memWrite;
   logic        memReady = 1'b1;
   logic        locked;
   logic        frameDone;
   logic        overflow;

   int vectors = 0;
   int miscompares = 0;

   logic [3:0]  pix [VA][HA];
   logic [22:0] exp_q[$];
   logic [22:0] got_q[$];
   int          fd_count = 0;
   logic        obs_locked;
   logic        obs_write;
   int          obs_pre;

   video_capture #(
      .H_START (HS),
      .H_ACTIVE(HA),
      .V_START (VS),
      .V_ACTIVE(VA),
      .SYNC_POL(1'b1)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .enable   (enable),
      .hSync    (hSync),
      .vSync    (vSync),
      .rgb      (rgb),
      .memAddr  (memAddr),
      .memData  (memData),
      .memWrite (memWrite),
      .memReady (memReady),
      .locked   (locked),
      .frameDone(frameDone),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (memWrite && memReady) got_q.push_back({memAddr, memData});
      if (frameDone) fd_count++;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no completion, required finish within time limit");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      hSync = 1'b0;
      vSync = 1'b0;
      for (int i = 0; i < n; i++) begin
         rgb = 4'($urandom);
         tick();
      end
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      enable = 1'b0;
      hSync = 1'b0;
      vSync = 1'b0;
      memReady = 1'b1;
      rgb = '0;
      tick();
      tick();
      reset = 1'b0;
      tick();
   endtask

   task automatic fill_pix(input bit constant, input logic [3:0] val);
      for (int i = 0; i < VA; i++)
         for (int j = 0; j < HA; j++)
            pix[i][j] = constant ? val : 4'($urandom);
   endtask

   // Reference: line l (hsync pulses since vsync) in the window maps row-major, two pixels per byte.
   task automatic model_frame(input int n_lines);
      for (int l = 1; l <= n_lines; l++)
         if (l >= VS && l < VE)
            for (int k = 0; k < HW; k++)
               exp_q.push_back({15'((l - VS) * HW + k), pix[l - VS][2 * k], pix[l - VS][2 * k + 1]});
   endtask

   task automatic drive_vsync();
      hSync = 1'b0;
      vSync = 1'b1;
      for (int i = 0; i < 4; i++) begin
         rgb = 4'($urandom);
         tick();
      end
      vSync = 1'b0;
      for (int i = 0; i < 2; i++) begin
         rgb = 4'($urandom);
         tick();
      end
   endtask

   // ev_kind: 0 none, 1 stall memReady for 16 cycles from ev_step, 2 drop enable at ev_step.
   task automatic drive_line(input int l, input int ev_step, input int ev_kind);
      hSync = 1'b1;
      for (int i = 0; i < 3; i++) begin
         rgb = 4'($urandom);
         tick();
      end
      hSync = 1'b0;
      for (int s = 0; s < LINE_LO; s++) begin
         if (ev_kind == 2 && s == ev_step + 1) obs_locked = locked;
         if (ev_kind == 1 && s == ev_step + 15) obs_write = memWrite;
         if (ev_kind == 1 && s == ev_step) begin
            memReady = 1'b0;
            obs_pre = got_q.size();
         end
         if (ev_kind == 1 && s == ev_step + 16) memReady = 1'b1;
         if (ev_kind == 2 && s == ev_step) enable = 1'b0;
         if (l >= VS && l < VE && s >= HS && s < HE) rgb = pix[l - VS][s - HS];
         else rgb = 4'($urandom);
         tick();
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      enable = 1'b1;
      hSync = 1'b1;
      vSync = 1'b1;
      rgb = 4'hf;
      tick();
      tick();
      vectors++; if (memWrite !== 1'b0) begin miscompares++; $display("FAIL reset_memWrite: got %b required 0", memWrite); end
      vectors++; if (memAddr !== 15'd0) begin miscompares++; $display("FAIL reset_memAddr: got %h required 0", memAddr); end
      vectors++; if (memData !== 8'd0) begin miscompares++; $display("FAIL reset_memData: got %h required 0", memData); end
      vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL reset_locked: got %b required 0", locked); end
      vectors++; if (frameDone !== 1'b0) begin miscompares++; $display("FAIL reset_frameDone: got %b required 0", frameDone); end
      vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_overflow: got %b required 0", overflow); end
      reset = 1'b0;
      enable = 1'b0;
      hSync = 1'b0;
      vSync = 1'b0;
      tick();
      vectors++; if (memWrite !== 1'b0) begin miscompares++; $display("FAIL post_reset_memWrite: got %b required 0", memWrite); end
   endtask

   task automatic test_full_frame();
      int base, fd0, n_got;
      apply_reset();
      enable = 1'b1;
      tick();
      fill_pix(1'b0, 4'h0);
      exp_q.delete();
      model_frame(VE + 1);
      base = got_q.size();
      fd0 = fd_count;
      drive_vsync();
      vectors++; if (locked !== 1'b1) begin miscompares++; $display("FAIL frame_locked: got %b required 1", locked); end
      for (int l = 1; l <= VE + 1; l++) drive_line(l, -1, 0);
      idle(8);
      n_got = got_q.size() - base;
      vectors++; if (n_got !== FRAME_BYTES) begin miscompares++; $display("FAIL frame_count: got %0d required %0d", n_got, FRAME_BYTES); end
      for (int i = 0; i < exp_q.size() && i < n_got; i++) begin
         vectors++;
         if (got_q[base + i] !== exp_q[i]) begin
            miscompares++;
            $display("FAIL frame_word[%0d]: got %h required %h", i, got_q[base + i], exp_q[i]);
         end
      end
      vectors++; if (fd_count - fd0 !== 1) begin miscompares++; $display("FAIL frame_done_count: got %0d required 1", fd_count - fd0); end
      vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL frame_overflow: got %b required 0", overflow); end
      vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL frame_rearmed_locked: got %b required 0", locked); end
   endtask

   task automatic test_constant_color();
      int base, n_got;
      apply_reset();
      enable = 1'b1;
      tick();
      fill_pix(1'b1, 4'b0100);
      exp_q.delete();
      model_frame(VE + 1);
      base = got_q.size();
      drive_vsync();
      for (int l = 1; l <= VE + 1; l++) drive_line(l, -1, 0);
      idle(8);
      n_got = got_q.size() - base;
      vectors++; if (n_got !== FRAME_BYTES) begin miscompares++; $display("FAIL const_count: got %0d required %0d", n_got, FRAME_BYTES); end
      for (int i = 0; i < n_got; i++) begin
         vectors++;
         if (got_q[base + i][7:0] !== 8'h44) begin
            miscompares++;
            $display("FAIL const_data[%0d]: got %h required 44", i, got_q[base + i][7:0]);
         end
      end
      if (n_got > HW) begin
         vectors++;
         if (got_q[base + HW][22:8] !== 15'(HW)) begin
            miscompares++;
            $display("FAIL const_line1_addr: got %0d required %0d", got_q[base + HW][22:8], HW);
         end
      end
   endtask

   task automatic test_backpressure();
      int base, n_got, held, j;
      apply_reset();
      enable = 1'b1;
      tick();
      fill_pix(1'b0, 4'h0);
      exp_q.delete();
      model_frame(VE + 1);
      base = got_q.size();
      drive_vsync();
      for (int l = 1; l <= VS; l++) drive_line(l, -1, 0);
      drive_line(VS + 1, HS + 2, 1);
      for (int l = VS + 2; l <= VE + 1; l++) drive_line(l, -1, 0);
      idle(8);
      n_got = got_q.size() - base;
      held = obs_pre - base + 4;
      vectors++; if (obs_write !== 1'b1) begin miscompares++; $display("FAIL stall_memWrite: got %b required 1", obs_write); end
      vectors++; if ((n_got < FRAME_BYTES) !== 1'b1) begin miscompares++; $display("FAIL stall_dropped: got %0d writes required fewer than %0d", n_got, FRAME_BYTES); end
      for (int i = 0; i < held && i < n_got; i++) begin
         vectors++;
         if (got_q[base + i] !== exp_q[i]) begin
            miscompares++;
            $display("FAIL stall_held[%0d]: got %h required %h", i, got_q[base + i], exp_q[i]);
         end
      end
      j = held;
      for (int i = held; i < n_got; i++) begin
         while (j < exp_q.size() && exp_q[j] !== got_q[base + i]) j++;
         vectors++;
         if (j >= exp_q.size()) begin
            miscompares++;
            $display("FAIL stall_order[%0d]: got %h required an in-order frame byte", i, got_q[base + i]);
         end else begin
            j++;
         end
      end
      vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL stall_overflow: got %b required 1", overflow); end
      apply_reset();
      vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL stall_overflow_cleared: got %b required 0", overflow); end
   endtask

   task automatic test_vsync_restart();
      int base, fd0, n_got, n_part;
      apply_reset();
      enable = 1'b1;
      tick();
      exp_q.delete();
      fill_pix(1'b0, 4'h0);
      model_frame(VS + 2);
      n_part = exp_q.size();
      base = got_q.size();
      fd0 = fd_count;
      drive_vsync();
      for (int l = 1; l <= VS + 2; l++) drive_line(l, -1, 0);
      fill_pix(1'b0, 4'h0);
      model_frame(VE + 1);
      drive_vsync();
      vectors++; if (locked !== 1'b1) begin miscompares++; $display("FAIL restart_locked: got %b required 1", locked); end
      for (int l = 1; l <= VE + 1; l++) drive_line(l, -1, 0);
      idle(8);
      n_got = got_q.size() - base;
      vectors++; if (n_got !== exp_q.size()) begin miscompares++; $display("FAIL restart_count: got %0d required %0d", n_got, exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < n_got; i++) begin
         vectors++;
         if (got_q[base + i] !== exp_q[i]) begin
            miscompares++;
            $display("FAIL restart_word[%0d]: got %h required %h", i, got_q[base + i], exp_q[i]);
         end
      end
      if (n_got > n_part) begin
         vectors++;
         if (got_q[base + n_part][22:8] !== 15'd0) begin
            miscompares++;
            $display("FAIL restart_addr0: got %0d required 0", got_q[base + n_part][22:8]);
         end
      end
      vectors++; if (fd_count - fd0 !== 1) begin miscompares++; $display("FAIL restart_done_count: got %0d required 1", fd_count - fd0); end
   endtask

   task automatic test_disable();
      int base, fd0, n_got, cnt_a;
      apply_reset();
      enable = 1'b1;
      tick();
      fill_pix(1'b0, 4'h0);
      exp_q.delete();
      model_frame(VE + 1);
      base = got_q.size();
      fd0 = fd_count;
      drive_vsync();
      for (int l = 1; l <= VS + 1; l++) drive_line(l, -1, 0);
      drive_line(VS + 2, HS + 7, 2);
      cnt_a = got_q.size();
      for (int l = VS + 3; l <= VE + 1; l++) drive_line(l, -1, 0);
      idle(8);
      n_got = got_q.size() - base;
      vectors++; if (obs_locked !== 1'b0) begin miscompares++; $display("FAIL disable_locked: got %b required 0", obs_locked); end
      vectors++;
      if (n_got < 2 * HW + 1 || n_got > 2 * HW + 4) begin
         miscompares++;
         $display("FAIL disable_count: got %0d required %0d..%0d", n_got, 2 * HW + 1, 2 * HW + 4);
      end
      for (int i = 0; i < n_got && i < exp_q.size(); i++) begin
         vectors++;
         if (got_q[base + i] !== exp_q[i]) begin
            miscompares++;
            $display("FAIL disable_word[%0d]: got %h required %h", i, got_q[base + i], exp_q[i]);
         end
      end
      vectors++; if (got_q.size() !== cnt_a) begin miscompares++; $display("FAIL disable_no_push: got %0d writes required %0d", got_q.size(), cnt_a); end
      vectors++; if (memWrite !== 1'b0) begin miscompares++; $display("FAIL disable_drained: got %b required 0", memWrite); end
      vectors++; if (fd_count - fd0 !== 0) begin miscompares++; $display("FAIL disable_done_count: got %0d required 0", fd_count - fd0); end
   endtask

   task automatic test_reset_midwrite();
      int base;
      apply_reset();
      enable = 1'b1;
      memReady = 1'b0;
      tick();
      fill_pix(1'b0, 4'h0);
      drive_vsync();
      for (int l = 1; l <= VS + 1; l++) drive_line(l, -1, 0);
      vectors++; if (memWrite !== 1'b1) begin miscompares++; $display("FAIL midwrite_pending: got %b required 1", memWrite); end
      reset = 1'b1;
      tick();
      vectors++; if (memWrite !== 1'b0) begin miscompares++; $display("FAIL midwrite_memWrite: got %b required 0", memWrite); end
      vectors++; if (memAddr !== 15'd0) begin miscompares++; $display("FAIL midwrite_memAddr: got %h required 0", memAddr); end
      vectors++; if (memData !== 8'd0) begin miscompares++; $display("FAIL midwrite_memData: got %h required 0", memData); end
      vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL midwrite_locked: got %b required 0", locked); end
      vectors++; if (frameDone !== 1'b0) begin miscompares++; $display("FAIL midwrite_frameDone: got %b required 0", frameDone); end
      vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL midwrite_overflow: got %b required 0", overflow); end
      reset = 1'b0;
      enable = 1'b0;
      memReady = 1'b1;
      base = got_q.size();
      idle(10);
      vectors++; if (got_q.size() - base !== 0) begin miscompares++; $display("FAIL midwrite_abandon: got %0d writes required 0", got_q.size() - base); end
   endtask

   initial begin
      test_reset();
      test_full_frame();
      test_constant_color();
      test_backpressure();
      test_vsync_restart();
      test_disable();
      test_reset_midwrite();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
